status_branch_unit: RTL and testbench
=====================================

Name: status_branch_unit

Overview:
Holds the 6502 processor status register P and runs the conditional-branch sequence. It takes the registered ALU flag byte and page-cross bit on the ALU's output side. It merges them into P under per-flag control and applies explicit flag ops, PLP loads and interrupt entry. It also evaluates branch conditions and steps the taken / page-cross cycles for the control unit.

Parameters:
RESET_P, 8'h24, reset value of P (bit5 reads 1, I=1, all other flags 0)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
alu_status  in  8  registered ALU flags: N=bit7, V=bit6, Z=bit1, C=bit0; other bits ignored
alu_bpage  in  1  registered ALU page-cross indication
flag_we  in  8  per-bit enable: load P bit from alu_status (only bits 7,6,1,0 act)
set_flags  in  8  per-bit force-to-1 (SEC/SEI/SED)
clr_flags  in  8  per-bit force-to-0 (CLC/CLI/CLD/CLV)
plp_load  in  1  load P from db_in (PLP/RTI)
db_in  in  8  pulled stack byte
irq_entry  in  1  interrupt/BRK entry: set I
push_brk  in  1  B bit value placed in p_push
p_out  out  8  current P; bit5 reads 1, bit4 reads 0
p_push  out  8  byte to push: {N,V,1,push_brk,D,I,Z,C}
branch_start  in  1  start branch; sampled only in IDLE
branch_op  in  3  opcode[7:5]; [2:1] selects flag (00 N, 01 V, 10 C, 11 Z); [0] is the required value
br_neg  in  1  branch offset sign (1 = negative)
br_busy  out  1  high in WAIT, CHECK and FIX
br_done  out  1  one-cycle pulse at the end of a branch
br_taken  out  1  valid with br_done
br_fix  out  1  high in FIX: control unit adjusts PCH
br_fix_dec  out  1  valid with br_fix: 1 = decrement PCH, 0 = increment

Behaviour:
- Reset:
  - P = RESET_P, so p_out = 8'h24.
  - FSM goes to IDLE.
  - br_busy, br_done, br_taken, br_fix and br_fix_dec are all 0.
  - A reset during any branch state aborts the branch with no br_done pulse.
- P storage:
  - Bits 7,6,3,2,1,0 are stored.
  - Bits 5 and 4 are not stored. They are forced to 1 and 0 on p_out and ignored on all loads.
- P update per clock edge:
  - If plp_load: P = db_in, with bits 5 and 4 forced.
  - Otherwise, per bit i: set_flags[i] gives 1, else clr_flags[i] gives 0, else flag_we[i] gives alu_status[i], else P holds.
  - irq_entry additionally forces bit2 = 1 and takes priority over clr_flags[2].
  - flag_we on bits 5, 4, 3 or 2 has no effect.
- p_push is combinational from the current P and push_brk.
- Branch condition: cond = P[sel] == branch_op[0], where sel maps 00→7, 01→6, 10→0, 11→1. It uses P before any update at the same edge.
- FSM states: IDLE, WAIT, CHECK, FIX, DONE.
  - IDLE, branch_start=1, cond false: next state DONE, taken register = 0.
  - IDLE, branch_start=1, cond true: next state WAIT, taken register = 1, br_neg latched. The ALU adds PCL+offset during WAIT.
  - WAIT: next state CHECK.
  - CHECK: alu_bpage is sampled. If 0, next state DONE. If 1, next state FIX.
  - FIX: one cycle; br_fix=1 and br_fix_dec = latched br_neg. Next state DONE.
  - DONE: br_done=1, br_taken = taken register. Next state IDLE; a new branch_start is accepted in that IDLE cycle.
- branch_start outside IDLE is ignored.
- Flag updates during a branch are allowed; the branch result is unaffected because cond is latched.
- Latency from the branch_start edge to br_done:
  - not taken: br_done high in the cycle immediately after;
  - taken, no page cross: br_done high 3 cycles after;
  - taken with page cross: br_done high 4 cycles after.

Test Plan:
- Reset then idle: p_out=8'h24 and all br_* outputs 0. Hold rst mid-CHECK: FSM returns to IDLE with no br_done.
- ALU merge: P=8'h24, alu_status=8'hC3, flag_we=8'hC3 → p_out=8'hE7. Then set_flags=8'h01 with flag_we=8'h01 and alu_status=8'h00 → C=1 (set wins). Then irq_entry with clr_flags=8'h04 → I=1.
- PLP/PHP: db_in=8'hFF with plp_load → p_out=8'hEF. Then push_brk=1 → p_push=8'hFF; push_brk=0 → p_push=8'hEF.
- Branch not taken: Z=0, branch_op=3'b111 (BEQ) → br_done one cycle later with br_taken=0; br_busy never high.
- Branch taken, same page: C=1, branch_op=3'b101 (BCS), alu_bpage=0 in CHECK → br_done 3 cycles after start, br_taken=1, br_fix never high.
- Taken with cross: N=0, branch_op=3'b000 (BPL), br_neg=1, alu_bpage=1 → br_fix=1 and br_fix_dec=1 3 cycles after start, then br_done. A branch_start pulsed during WAIT is ignored.

Source files
------------

// File: rtl/status_branch_unit.sv
// Processor status register P and conditional-branch sequencer.
// P merges registered ALU flags under per-bit control, takes explicit
// set/clear ops, PLP/RTI loads and interrupt entry. The branch FSM
// evaluates the condition against the current P, then steps the
// taken / page-cross cycles for the control unit.
module status_branch_unit #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_status,
  input  logic       alu_bpage,
  input  logic [7:0] flag_we,
  input  logic [7:0] set_flags,
  input  logic [7:0] clr_flags,
  input  logic       plp_load,
  input  logic [7:0] db_in,
  input  logic       irq_entry,
  input  logic       push_brk,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  input  logic       branch_start,
  input  logic [2:0] branch_op,
  input  logic       br_neg,
  output logic       br_busy,
  output logic       br_done,
  output logic       br_taken,
  output logic       br_fix,
  output logic       br_fix_dec
);

  // Only N, V, Z and C can be loaded from the ALU flag byte.
  localparam logic [7:0] ALU_FLAG_MASK = 8'hC3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    CHECK = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } br_state_t;

  // Bit 5 always reads 1 and bit 4 always reads 0; they are never stored.
  function automatic logic [7:0] force_fixed_bits(input logic [7:0] v);
    logic [7:0] r;
    r    = v;
    r[5] = 1'b1;
    r[4] = 1'b0;
    return r;
  endfunction

  logic [7:0] p_q;
  logic [7:0] p_nxt;
  logic [7:0] we_eff;
  br_state_t  state_q;
  br_state_t  state_nxt;
  logic       taken_q;
  logic       neg_q;
  logic       cond;
  logic       sel_bit;

  assign we_eff = flag_we & ALU_FLAG_MASK;

  // Next value of P: PLP load wins, otherwise set > clear > ALU load > hold.
  always_comb begin
    p_nxt = p_q;
    if (plp_load) begin
      p_nxt = db_in;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (set_flags[i])      p_nxt[i] = 1'b1;
        else if (clr_flags[i]) p_nxt[i] = 1'b0;
        else if (we_eff[i])    p_nxt[i] = alu_status[i];
      end
      // Interrupt entry masks further IRQs regardless of a concurrent CLI.
      if (irq_entry) p_nxt[2] = 1'b1;
    end
    p_nxt = force_fixed_bits(p_nxt);
  end

  // P register.
  always_ff @(posedge clk) begin
    if (rst) p_q <= force_fixed_bits(RESET_P);
    else     p_q <= p_nxt;
  end

  assign p_out  = p_q;
  assign p_push = {p_q[7], p_q[6], 1'b1, push_brk, p_q[3], p_q[2], p_q[1], p_q[0]};

  // Branch condition from the selected flag, using P before this edge's update.
  always_comb begin
    case (branch_op[2:1])
      2'b00:   sel_bit = p_q[7];
      2'b01:   sel_bit = p_q[6];
      2'b10:   sel_bit = p_q[0];
      default: sel_bit = p_q[1];
    endcase
    cond = (sel_bit == branch_op[0]);
  end

  // Branch FSM state register plus the latched taken flag and offset sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == IDLE && branch_start) begin
        taken_q <= cond;
        neg_q   <= br_neg;
      end
    end
  end

  // Branch FSM next state and Moore outputs.
  always_comb begin
    state_nxt  = state_q;
    br_busy    = 1'b0;
    br_done    = 1'b0;
    br_taken   = 1'b0;
    br_fix     = 1'b0;
    br_fix_dec = 1'b0;
    case (state_q)
      IDLE: begin
        if (branch_start) state_nxt = cond ? WAIT : DONE;
      end
      WAIT: begin
        br_busy   = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        br_busy   = 1'b1;
        state_nxt = alu_bpage ? FIX : DONE;
      end
      FIX: begin
        br_busy    = 1'b1;
        br_fix     = 1'b1;
        br_fix_dec = neg_q;
        state_nxt  = DONE;
      end
      DONE: begin
        br_done   = 1'b1;
        br_taken  = taken_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed bench for status_branch_unit: flag merge, PLP/PHP and the
// three branch timings, with a scoreboard for branch results.
module tb_status_branch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_status;
  logic       alu_bpage;
  logic [7:0] flag_we;
  logic [7:0] set_flags;
  logic [7:0] clr_flags;
  logic       plp_load;
  logic [7:0] db_in;
  logic       irq_entry;
  logic       push_brk;
  logic [7:0] p_out;
  logic [7:0] p_push;
  logic       branch_start;
  logic [2:0] branch_op;
  logic       br_neg;
  logic       br_busy;
  logic       br_done;
  logic       br_taken;
  logic       br_fix;
  logic       br_fix_dec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic taken;
    int   lat;
    int   fix_cyc;
    logic fix_dec;
  } br_exp_t;

  br_exp_t sb[$];

  status_branch_unit #(.RESET_P(8'h24)) dut (
    .clk(clk), .rst(rst),
    .alu_status(alu_status), .alu_bpage(alu_bpage),
    .flag_we(flag_we), .set_flags(set_flags), .clr_flags(clr_flags),
    .plp_load(plp_load), .db_in(db_in), .irq_entry(irq_entry),
    .push_brk(push_brk), .p_out(p_out), .p_push(p_push),
    .branch_start(branch_start), .branch_op(branch_op), .br_neg(br_neg),
    .br_busy(br_busy), .br_done(br_done), .br_taken(br_taken),
    .br_fix(br_fix), .br_fix_dec(br_fix_dec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    flag_we = 8'h00; set_flags = 8'h00; clr_flags = 8'h00;
    plp_load = 1'b0; irq_entry = 1'b0;
  endtask

  // Launch one branch, push its expected outcome, then watch the DUT for up
  // to 8 cycles and compare what it produced against the popped entry.
  task automatic run_branch(input string tag, input logic [2:0] op, input logic neg,
                            input logic bpage, input logic exp_taken, input int exp_lat,
                            input int exp_fix, input logic pulse_in_wait,
                            input logic [7:0] set_mid);
    br_exp_t e;
    int   done_cyc = 0;
    int   fix_cyc  = 0;
    logic fix_dec_obs = 1'b0;
    logic taken_obs   = 1'b0;
    logic busy_seen   = 1'b0;
    branch_op = op; br_neg = neg; alu_bpage = bpage; branch_start = 1'b1;
    sb.push_back('{taken: exp_taken, lat: exp_lat, fix_cyc: exp_fix, fix_dec: neg});
    tick();
    branch_start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (br_busy) busy_seen = 1'b1;
      if (br_fix && fix_cyc == 0) begin
        fix_cyc = cyc;
        fix_dec_obs = br_fix_dec;
      end
      if (br_done) begin
        done_cyc  = cyc;
        taken_obs = br_taken;
        break;
      end
      branch_start = pulse_in_wait && (cyc == 1);
      set_flags    = (cyc == 2) ? set_mid : 8'h00;
      tick();
      branch_start = 1'b0;
      set_flags    = 8'h00;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, done_cyc, e.lat);
      check({tag, "_taken"}, taken_obs, e.taken);
      check({tag, "_fix_cycle"}, fix_cyc, e.fix_cyc);
      if (e.fix_cyc != 0) check({tag, "_fix_dec"}, fix_dec_obs, e.fix_dec);
      check({tag, "_busy_seen"}, busy_seen, (e.lat > 1) ? 1'b1 : 1'b0);
    end
    tick();
    check({tag, "_done_pulse"}, br_done, 1'b0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; alu_status = 8'h00; alu_bpage = 1'b0; db_in = 8'h00;
    push_brk = 1'b0; branch_start = 1'b0; branch_op = 3'b000; br_neg = 1'b0;
    clear_ctl();
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_p_out", p_out, 8'h24);
    check("rst_busy", br_busy, 1'b0);
    check("rst_done", br_done, 1'b0);
    check("rst_taken", br_taken, 1'b0);
    check("rst_fix", br_fix, 1'b0);
    check("rst_fix_dec", br_fix_dec, 1'b0);

    // ALU merge of N,V,Z,C
    alu_status = 8'hC3; flag_we = 8'hC3;
    tick(); clear_ctl();
    check("alu_merge", p_out, 8'hE7);

    // flag_we on D/I/bits5,4 has no effect
    alu_status = 8'h00; flag_we = 8'h3C;
    tick(); clear_ctl();
    check("we_ignored_bits", p_out, 8'hE7);

    // CLC, then set wins over ALU load of 0
    clr_flags = 8'h01;
    tick(); clear_ctl();
    check("clc", p_out, 8'hE6);
    set_flags = 8'h01; flag_we = 8'h01; alu_status = 8'h00;
    tick(); clear_ctl();
    check("set_wins", p_out, 8'hE7);

    // CLI, then irq_entry beats a concurrent CLI
    clr_flags = 8'h04;
    tick(); clear_ctl();
    check("cli", p_out, 8'hE3);
    irq_entry = 1'b1; clr_flags = 8'h04;
    tick(); clear_ctl();
    check("irq_over_cli", p_out, 8'hE7);

    // PLP with bits 5/4 forced, then PHP byte
    db_in = 8'hFF; plp_load = 1'b1;
    tick(); clear_ctl();
    check("plp", p_out, 8'hEF);
    push_brk = 1'b1; #1;
    check("php_brk1", p_push, 8'hFF);
    push_brk = 1'b0; #1;
    check("php_brk0", p_push, 8'hEF);

    // BEQ with Z=0: not taken
    clr_flags = 8'h02;
    tick(); clear_ctl();
    check("clear_z", p_out, 8'hED);
    run_branch("beq_nt", 3'b111, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 8'h00);

    // BCS with C=1, same page
    run_branch("bcs_t", 3'b101, 1'b0, 1'b0, 1'b1, 3, 0, 1'b0, 8'h00);

    // BPL with N=0, backward across a page; start pulse in WAIT ignored,
    // and setting N mid-branch does not change the outcome
    clr_flags = 8'h80;
    tick(); clear_ctl();
    check("clear_n", p_out, 8'h6D);
    run_branch("bpl_x", 3'b000, 1'b1, 1'b1, 1'b1, 4, 3, 1'b1, 8'h80);
    check("n_set_mid", p_out, 8'hED);

    // Reset while in CHECK aborts the branch
    branch_op = 3'b101; alu_bpage = 1'b0; branch_start = 1'b1;
    tick(); branch_start = 1'b0;
    tick();
    check("pre_rst_busy", br_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", br_busy, 1'b0);
    check("mid_rst_p_out", p_out, 8'h24);
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (br_done) done_seen++;
      tick();
    end
    check("mid_rst_no_done", done_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
